// File: rtl/bounce_controller_pkg.sv
// -----------------------------------------------------------------------------
// bouncy_pkg : shared types and constants for the bounce controller slice.
//   COORD_W          width of capsule center coordinates
//   VEL_W            width of signed velocity / angular velocity values
//   state_t          bounce controller FSM state encoding
//   VEL_MIN/VEL_MAX  extreme two's complement velocity values; the saturating
//                    negator maps VEL_MIN onto VEL_MAX
// No ports (package).
// -----------------------------------------------------------------------------
package bouncy_pkg;

    localparam int COORD_W = 10;
    localparam int VEL_W   = 6;

    localparam logic signed [VEL_W-1:0] VEL_MIN = 6'sh20;  // -32
    localparam logic signed [VEL_W-1:0] VEL_MAX = 6'sh1f;  // +31

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        REFLECT = 2'd2,
        FIRE    = 2'd3
    } state_t;

endpackage

// File: rtl/bounce_controller_if.sv
// -----------------------------------------------------------------------------
// bounce_controller_if : connection between the kinematics stage and the bounce
// controller.
//   frame_start   kinematics -> controller, one-cycle frame pulse
//   center_x/y    kinematics -> controller, current capsule center
//   update        controller -> kinematics, one-cycle step strobe
//   vx/vy/w       controller -> kinematics, signed velocities and spin
//   bounce        controller -> kinematics, one-cycle reflection pulse
//   bounce_count  controller -> kinematics, wrapping reflection count
// Modports: master (kinematics side), slave (bounce controller side).
// -----------------------------------------------------------------------------
interface bounce_controller_if;
    import bouncy_pkg::*;

    logic                      frame_start;
    logic [COORD_W-1:0]        center_x;
    logic [COORD_W-1:0]        center_y;
    logic                      update;
    logic signed [VEL_W-1:0]   vx;
    logic signed [VEL_W-1:0]   vy;
    logic signed [VEL_W-1:0]   w;
    logic                      bounce;
    logic [7:0]                bounce_count;

    modport master (
        output frame_start, center_x, center_y,
        input  update, vx, vy, w, bounce, bounce_count
    );

    modport slave (
        input  frame_start, center_x, center_y,
        output update, vx, vy, w, bounce, bounce_count
    );

endinterface

// File: rtl/bounce_controller_sat_negate.sv
// -----------------------------------------------------------------------------
// sat_negate : combinational saturating two's complement negator.
//   din   in  VEL_W  signed value
//   dout  out VEL_W  -din, except the most negative value which maps to the
//                    most positive value (the exact result is unrepresentable)
// -----------------------------------------------------------------------------
module sat_negate
    import bouncy_pkg::*;
(
    input  logic signed [VEL_W-1:0] din,
    output logic signed [VEL_W-1:0] dout
);

    // Negate, clamping the single overflow case.
    always_comb begin
        dout = 6'sd0;
        if (din == VEL_MIN) begin
            dout = VEL_MAX;
        end else begin
            dout = 6'sd0 - din;
        end
    end

endmodule

// File: rtl/bounce_controller.sv
// -----------------------------------------------------------------------------
// bounce_controller : once every FRAME_DIV frames, checks the capsule center
// against the arena limits, reflects the velocity of every axis that is moving
// into a wall, and strobes the kinematics stage with the new motion values.
//
// Ports:
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   bif   slave modport of bounce_controller_if (frame_start, center_x/y in;
//         update, vx, vy, w, bounce, bounce_count out; all outputs registered)
//
// Build option: define BOUNCE_SPIN_EN to negate the spin w on every bounce;
// without it w stays at INIT_W.
//
// Step timing (FRAME_DIV = 1): frame_start in cycle T, CHECK in T+1,
// REFLECT in T+2, update/bounce high in T+3 with the new velocities visible.
// -----------------------------------------------------------------------------
module bounce_controller
    import bouncy_pkg::*;
#(
    parameter logic [COORD_W-1:0]      X_MIN     = 10'd32,
    parameter logic [COORD_W-1:0]      X_MAX     = 10'd607,
    parameter logic [COORD_W-1:0]      Y_MIN     = 10'd32,
    parameter logic [COORD_W-1:0]      Y_MAX     = 10'd447,
    parameter logic signed [VEL_W-1:0] INIT_VX   = 6'sd5,
    parameter logic signed [VEL_W-1:0] INIT_VY   = 6'sd3,
    parameter logic signed [VEL_W-1:0] INIT_W    = 6'sd2,
    parameter int                      FRAME_DIV = 1
) (
    input  logic                clk,
    input  logic                rst,
    bounce_controller_if.slave  bif
);

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    state_t                  state_r, state_s;
    logic [7:0]              frame_cnt_r, frame_cnt_s;
    logic                    hit_x_r, hit_x_s;
    logic                    hit_y_r, hit_y_s;
    logic signed [VEL_W-1:0] vx_r, vx_s;
    logic signed [VEL_W-1:0] vy_r, vy_s;
    logic signed [VEL_W-1:0] w_r, w_s;
    logic                    update_r, update_s;
    logic                    bounce_r, bounce_s;
    logic [7:0]              count_r, count_s;

    logic signed [VEL_W-1:0] vx_neg_s;
    logic signed [VEL_W-1:0] vy_neg_s;
    logic                    hit_x_now_s;
    logic                    hit_y_now_s;

    sat_negate u_neg_vx (.din(vx_r), .dout(vx_neg_s));
    sat_negate u_neg_vy (.din(vy_r), .dout(vy_neg_s));

`ifdef BOUNCE_SPIN_EN
    logic signed [VEL_W-1:0] w_neg_s;
    sat_negate u_neg_w (.din(w_r), .dout(w_neg_s));
`endif

    // Wall contact on an axis only counts when moving towards that wall, so a
    // zero velocity never hits.
    always_comb begin
        hit_x_now_s = ((bif.center_x <= X_MIN) && (vx_r < 6'sd0)) ||
                      ((bif.center_x >= X_MAX) && (vx_r > 6'sd0));
        hit_y_now_s = ((bif.center_y <= Y_MIN) && (vy_r < 6'sd0)) ||
                      ((bif.center_y >= Y_MAX) && (vy_r > 6'sd0));
    end

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        state_s     = state_r;
        frame_cnt_s = frame_cnt_r;
        hit_x_s     = hit_x_r;
        hit_y_s     = hit_y_r;
        vx_s        = vx_r;
        vy_s        = vy_r;
        w_s         = w_r;
        update_s    = 1'b0;
        bounce_s    = 1'b0;
        count_s     = count_r;

        case (state_r)
            IDLE: begin
                if (bif.frame_start) begin
                    if (frame_cnt_r == DIV_LAST) begin
                        frame_cnt_s = 8'd0;
                        state_s     = CHECK;
                    end else begin
                        frame_cnt_s = frame_cnt_r + 8'd1;
                        state_s     = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            CHECK: begin
                hit_x_s = hit_x_now_s;
                hit_y_s = hit_y_now_s;
                state_s = REFLECT;
            end

            REFLECT: begin
                if (hit_x_r) begin
                    vx_s = vx_neg_s;
                end else begin
                    vx_s = vx_r;
                end
                if (hit_y_r) begin
                    vy_s = vy_neg_s;
                end else begin
                    vy_s = vy_r;
                end
                // A corner hit is still a single bounce.
                if (hit_x_r || hit_y_r) begin
                    bounce_s = 1'b1;
                    count_s  = count_r + 8'd1;
`ifdef BOUNCE_SPIN_EN
                    w_s      = w_neg_s;
`endif
                end else begin
                    bounce_s = 1'b0;
                    count_s  = count_r;
                end
                // Registered, so the strobe lands in the FIRE cycle.
                update_s = 1'b1;
                state_s  = FIRE;
            end

            FIRE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            frame_cnt_r <= 8'd0;
            hit_x_r     <= 1'b0;
            hit_y_r     <= 1'b0;
            vx_r        <= INIT_VX;
            vy_r        <= INIT_VY;
            w_r         <= INIT_W;
            update_r    <= 1'b0;
            bounce_r    <= 1'b0;
            count_r     <= 8'd0;
        end else begin
            state_r     <= state_s;
            frame_cnt_r <= frame_cnt_s;
            hit_x_r     <= hit_x_s;
            hit_y_r     <= hit_y_s;
            vx_r        <= vx_s;
            vy_r        <= vy_s;
            w_r         <= w_s;
            update_r    <= update_s;
            bounce_r    <= bounce_s;
            count_r     <= count_s;
        end
    end

    assign bif.update       = update_r;
    assign bif.bounce       = bounce_r;
    assign bif.bounce_count = count_r;
    assign bif.vx           = vx_r;
    assign bif.vy           = vy_r;
    assign bif.w            = w_r;

endmodule

// File: tb/tb_bounce_controller.sv
// -----------------------------------------------------------------------------
// tb_bounce_controller : scoreboard bench for bounce_controller.
// Five instances with different reset velocities / frame dividers share clk and
// rst. The stimulus process drives each instance cycle by cycle and feeds the
// same inputs to a reference model; every completed step pushes its expected
// FIRE-cycle outputs into a queue. A monitor pops and compares whenever an
// update is due or seen. Honours BOUNCE_SPIN_EN like the design.
// -----------------------------------------------------------------------------
module tb_bounce_controller;

    localparam int NI = 5;

    function automatic int ivx(int g);
        case (g)
            1:       return -4;
            2:       return -32;
            3:       return 0;
            default: return 5;
        endcase
    endfunction

    function automatic int ivy(int g);
        case (g)
            1:       return 6;
            2:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int fdiv(int g);
        case (g)
            4:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic int sat_neg(int v);
        if (v == -32) return 31;
        return -v;
    endfunction

    typedef struct {
        int inst;
        int cyc;
        int vx;
        int vy;
        int w;
        bit bnc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    logic              fs  [NI];
    logic [9:0]        cx  [NI];
    logic [9:0]        cy  [NI];
    logic              upd [NI];
    logic              bnc [NI];
    logic signed [5:0] vx_o[NI];
    logic signed [5:0] vy_o[NI];
    logic signed [5:0] w_o [NI];
    logic [7:0]        cnt_o[NI];

    int   ntest = 0;
    int   nfail = 0;
    int   upd_seen[NI];
    exp_t q[$];

    // reference model state
    int mvx[NI], mvy[NI], mw[NI], mcnt[NI], mfc[NI], macc[NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bounce_controller_if bif();
        bounce_controller #(
            .X_MIN(10'd32), .X_MAX(10'd607), .Y_MIN(10'd32), .Y_MAX(10'd447),
            .INIT_VX(6'(ivx(g))), .INIT_VY(6'(ivy(g))), .INIT_W(6'sd2),
            .FRAME_DIV(fdiv(g))
        ) dut (
            .clk(clk),
            .rst(rst),
            .bif(bif.slave)
        );
        assign bif.frame_start = fs[g];
        assign bif.center_x    = cx[g];
        assign bif.center_y    = cy[g];
        assign upd[g]   = bif.update;
        assign bnc[g]   = bif.bounce;
        assign vx_o[g]  = bif.vx;
        assign vy_o[g]  = bif.vy;
        assign w_o[g]   = bif.w;
        assign cnt_o[g] = bif.bounce_count;
    end

    task automatic chk(string name, int got, int want);
        ntest++;
        if (got != want) begin
            nfail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mvx[i] = ivx(i); mvy[i] = ivy(i); mw[i] = 2;
            mcnt[i] = 0; mfc[i] = 0; macc[i] = -100;
        end
    endtask

    // Model one clock cycle t with the inputs currently applied.
    // A step accepted in cycle c samples the centers in c+1, reports in c+3
    // and keeps the controller busy (frame pulses ignored) through c+3.
    task automatic model_cycle(int t);
        exp_t keep[$];
        exp_t e;
        bit hx, hy;
        if (rst) begin
            model_reset();
            foreach (q[k]) if (q[k].cyc <= t) keep.push_back(q[k]);
            q = keep;
            return;
        end
        for (int i = 0; i < NI; i++) begin
            if (t == macc[i] + 1) begin
                hx = (int'(cx[i]) <= 32 && mvx[i] < 0) || (int'(cx[i]) >= 607 && mvx[i] > 0);
                hy = (int'(cy[i]) <= 32 && mvy[i] < 0) || (int'(cy[i]) >= 447 && mvy[i] > 0);
                if (hx) mvx[i] = sat_neg(mvx[i]);
                if (hy) mvy[i] = sat_neg(mvy[i]);
                if (hx || hy) begin
                    mcnt[i] = (mcnt[i] + 1) % 256;
`ifdef BOUNCE_SPIN_EN
                    mw[i] = sat_neg(mw[i]);
`endif
                end
                e.inst = i; e.cyc = macc[i] + 3; e.vx = mvx[i]; e.vy = mvy[i];
                e.w = mw[i]; e.bnc = hx || hy; e.cnt = mcnt[i];
                q.push_back(e);
            end
            if (fs[i] && t > macc[i] + 3) begin
                mfc[i]++;
                if (mfc[i] == fdiv(i)) begin
                    mfc[i] = 0;
                    macc[i] = t;
                end
            end
        end
    endtask

    task automatic step();
        model_cycle(cyc);
        @(posedge clk);
        #1;
    endtask

    // Single frame pulse on one instance, then hold centers while the step runs.
    task automatic fire(int i, int x, int y);
        cx[i] = 10'(x); cy[i] = 10'(y);
        fs[i] = 1'b1;
        step();
        fs[i] = 1'b0;
        repeat (4) step();
    endtask

    function automatic int pick(int lo, int hi);
        case ($urandom_range(0, 5))
            0:       return lo;
            1:       return hi;
            2:       return lo - int'($urandom_range(0, 20));
            3:       return hi + int'($urandom_range(0, 20));
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    // Monitor: compare every due or observed update against the scoreboard.
    initial begin
        exp_t e;
        for (int i = 0; i < NI; i++) upd_seen[i] = 0;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                ntest++; nfail++;
                $display("FAIL step_missing dut%0d: no update by cycle %0d", e.inst, cyc);
            end
            for (int i = 0; i < NI; i++) begin
                if (upd[i] === 1'b1) upd_seen[i]++;
                if (q.size() > 0 && q[0].cyc == cyc && q[0].inst == i) begin
                    e = q.pop_front();
                    ntest++;
                    if (upd[i] !== 1'b1 || bnc[i] !== e.bnc || int'(vx_o[i]) != e.vx ||
                        int'(vy_o[i]) != e.vy || int'(w_o[i]) != e.w || int'(cnt_o[i]) != e.cnt) begin
                        nfail++;
                        $display("FAIL step dut%0d cyc %0d: got upd=%b bnc=%b vx=%0d vy=%0d w=%0d cnt=%0d want upd=1 bnc=%b vx=%0d vy=%0d w=%0d cnt=%0d",
                                 i, cyc, upd[i], bnc[i], vx_o[i], vy_o[i], w_o[i], cnt_o[i],
                                 e.bnc, e.vx, e.vy, e.w, e.cnt);
                    end
                end else if (upd[i] !== 1'b0) begin
                    ntest++; nfail++;
                    $display("FAIL unexpected_update dut%0d cyc %0d: got update=%b want 0", i, cyc, upd[i]);
                end
                if (bnc[i] !== 1'b0 && upd[i] !== 1'b1) begin
                    ntest++; nfail++;
                    $display("FAIL stray_bounce dut%0d cyc %0d: got bounce=%b want 0", i, cyc, bnc[i]);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int seen4;
        for (int i = 0; i < NI; i++) begin
            fs[i] = 1'b0; cx[i] = 10'd320; cy[i] = 10'd240;
        end
        model_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // reset state
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_update%0d", i), int'(upd[i]), 0);
            chk($sformatf("rst_bounce%0d", i), int'(bnc[i]), 0);
            chk($sformatf("rst_count%0d", i), int'(cnt_o[i]), mcnt[i]);
            chk($sformatf("rst_vx%0d", i), int'(vx_o[i]), mvx[i]);
            chk($sformatf("rst_vy%0d", i), int'(vy_o[i]), mvy[i]);
            chk($sformatf("rst_w%0d", i), int'(w_o[i]), mw[i]);
        end

        // directed cases
        fire(0, 320, 240);      // no hit, latency
        fire(0, 607, 240);      // right wall
        fire(1, 32, 447);       // corner
        fire(2, 10, 240);       // -32 saturates to +31
        fire(3, 0, 240);        // zero velocity never hits
        chk("sat_vx", int'(vx_o[2]), 31);
        chk("zero_vx", int'(vx_o[3]), 0);
        chk("zero_count", int'(cnt_o[3]), 0);

        // frame divider with an extra pulse landing in CHECK
        seen4 = upd_seen[4];
        for (int k = 0; k < 6; k++) begin
            fs[4] = 1'b1;
            step();
            fs[4] = 1'b0;
            if (k == 2) begin
                fs[4] = 1'b1;
                step();
                fs[4] = 1'b0;
            end
            repeat (999) step();
        end
        chk("div3_updates", upd_seen[4] - seen4, 2);

        // reset in REFLECT aborts the step
        fire(0, (mvx[0] > 0) ? 607 : 32, 240);
        cx[0] = (mvx[0] > 0) ? 10'd607 : 10'd32;
        fs[0] = 1'b1;
        step();
        fs[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        chk("abort_vx", int'(vx_o[0]), 5);
        chk("abort_vy", int'(vy_o[0]), 3);
        chk("abort_w", int'(w_o[0]), 2);
        chk("abort_count", int'(cnt_o[0]), 0);

        // 256 bounces wrap the counter
        for (int k = 0; k < 256; k++) fire(0, (mvx[0] > 0) ? 607 : 32, 240);
        chk("wrap_count", int'(cnt_o[0]), 0);

        // randomized traffic on all instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++) begin
                fs[i] = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 1) == 0) begin
                    cx[i] = 10'(pick(32, 607));
                    cy[i] = 10'(pick(32, 447));
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < NI; i++) fs[i] = 1'b0;
        repeat (10) step();
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
